// File: rtl/lcd_responder.sv
// ============================================================================
// Module      : lcd_responder
// Description : HD44780-compatible bus responder. Device end of the 8-bit LCD
//               parallel bus (rs/rw/e/data). Decodes status reads, command
//               writes, data writes and data reads. Holds a 2x16 character
//               DDRAM and the display-control flags. A registered side port
//               exposes the screen contents to a renderer or scoreboard.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   rs_pin       in   register select (0 instr/status, 1 data)
//   rw_pin       in   1 host read, 0 host write
//   e_pin        in   enable strobe; access taken on its falling edge
//   data_pins    io   bus, driven only while e_pin && rw_pin
//   disp_addr    in   side-port index {line, column[3:0]}
//   disp_char    out  DDRAM[disp_addr], one cycle latency
//   display_on   out  D flag
//   cursor_on    out  C flag
//   blink_on     out  B flag
//   cursor_addr  out  address counter (AC)
//   drop_count   out  accesses ignored while busy
// Optional build macro
//   LCD_DROP_CNT_EN : enables the saturating dropped-access counter;
//                     without it drop_count is tied to zero.
// ============================================================================
`default_nettype none

module lcd_responder #(
    parameter int BUSY_CYCLES       = 40,
    parameter int CLEAR_BUSY_CYCLES = 160,
    parameter int DROP_CNT_W        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rs_pin,
    input  logic                  rw_pin,
    input  logic                  e_pin,
    inout  tri   [7:0]            data_pins,
    input  logic [4:0]            disp_addr,
    output logic [7:0]            disp_char,
    output logic                  display_on,
    output logic                  cursor_on,
    output logic                  blink_on,
    output logic [6:0]            cursor_addr,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam int MAX_BUSY = (BUSY_CYCLES > CLEAR_BUSY_CYCLES) ? BUSY_CYCLES : CLEAR_BUSY_CYCLES;
    localparam int CNT_W    = $clog2(MAX_BUSY + 1);
    localparam logic [CNT_W-1:0] C_BUSY  = CNT_W'(BUSY_CYCLES);
    localparam logic [CNT_W-1:0] C_CLEAR = CNT_W'(CLEAR_BUSY_CYCLES);
    localparam logic [7:0]       C_SPACE = 8'h20;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [7:0]       mem_q [32];

    // Two-stage synchronisers, then one extra stage holding the values
    // from the previous cycle so a falling edge can use the last "e high" data.
    logic [1:0]       rs_s_q, rw_s_q, e_s_q;
    logic [7:0]       data_s1_q, data_s2_q;
    logic             rs_p_q, rw_p_q, e_p_q;
    logic [7:0]       data_p_q;

    state_t           state_q, state_d;
    logic [4:0]       fill_idx_q, fill_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       ac_q, ac_d;
    logic             id_q, id_d;
    logic             disp_q, disp_d;
    logic             curs_q, curs_d;
    logic             blink_q, blink_d;
    logic [7:0]       disp_char_q;

    logic             busy;
    logic             fall, is_cmd, is_wr, is_rd, access, accept, drop;
    logic             mem_we;
    logic [4:0]       mem_wa;
    logic [7:0]       mem_wd;
    logic [7:0]       rd_val;

    function automatic logic [4:0] ac_idx(input logic [6:0] ac);
        return {ac[6], ac[3:0]};
    endfunction

    // Address counter step across the two 16-entry line windows.
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        logic [6:0] r;
        if (inc) begin
            if (ac == 7'h0F)      r = 7'h40;
            else if (ac == 7'h4F) r = 7'h00;
            else                  r = ac + 7'd1;
        end else begin
            if (ac == 7'h00)      r = 7'h4F;
            else if (ac == 7'h40) r = 7'h0F;
            else                  r = ac - 7'd1;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    assign busy   = (cnt_q != '0);
    assign fall   = e_p_q & ~e_s_q[1];
    assign is_cmd = fall & ~rs_p_q & ~rw_p_q;
    assign is_wr  = fall &  rs_p_q & ~rw_p_q;
    assign is_rd  = fall &  rs_p_q &  rw_p_q;
    assign access = is_cmd | is_wr | is_rd;
    assign accept = access & ~busy;
    assign drop   = access &  busy;

    always_comb begin
        state_d    = state_q;
        fill_idx_d = fill_idx_q;
        cnt_d      = busy ? (cnt_q - 1'b1) : cnt_q;
        ac_d       = ac_q;
        id_d       = id_q;
        disp_d     = disp_q;
        curs_d     = curs_q;
        blink_d    = blink_q;
        mem_we     = 1'b0;
        mem_wa     = ac_idx(ac_q);
        mem_wd     = data_p_q;

        // Clear fill: one space per cycle. Busy is always set while filling,
        // so no host write can collide with the fill on the single write port.
        if (state_q == S_FILL) begin
            mem_we     = 1'b1;
            mem_wa     = fill_idx_q;
            mem_wd     = C_SPACE;
            fill_idx_d = fill_idx_q + 5'd1;
            if (fill_idx_q == 5'd31) begin
                state_d = S_IDLE;
            end
        end

        if (accept) begin
            if (is_wr) begin
                mem_we = 1'b1;
                ac_d   = ac_step(ac_q, id_q);
                cnt_d  = C_BUSY;
            end else if (is_rd) begin
                ac_d   = ac_step(ac_q, id_q);
            end else begin
                // Command: highest set bit selects the instruction.
                if (data_p_q[7]) begin
                    ac_d  = {data_p_q[6], 2'b00, data_p_q[3:0]};
                    cnt_d = C_BUSY;
                end else if (data_p_q[6:4] != 3'b000) begin
                    cnt_d = C_BUSY;
                end else if (data_p_q[3]) begin
                    disp_d  = data_p_q[2];
                    curs_d  = data_p_q[1];
                    blink_d = data_p_q[0];
                    cnt_d   = C_BUSY;
                end else if (data_p_q[2]) begin
                    id_d  = data_p_q[1];
                    cnt_d = C_BUSY;
                end else if (data_p_q[1]) begin
                    ac_d  = 7'h00;
                    cnt_d = C_CLEAR;
                end else if (data_p_q[0]) begin
                    ac_d       = 7'h00;
                    id_d       = 1'b1;
                    state_d    = S_FILL;
                    fill_idx_d = 5'd0;
                    cnt_d      = C_CLEAR;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_s_q      <= '0;
            rw_s_q      <= '0;
            e_s_q       <= '0;
            data_s1_q   <= '0;
            data_s2_q   <= '0;
            rs_p_q      <= 1'b0;
            rw_p_q      <= 1'b0;
            e_p_q       <= 1'b0;
            data_p_q    <= '0;
            state_q     <= S_FILL;
            fill_idx_q  <= 5'd0;
            cnt_q       <= C_CLEAR;
            ac_q        <= 7'h00;
            id_q        <= 1'b1;
            disp_q      <= 1'b0;
            curs_q      <= 1'b0;
            blink_q     <= 1'b0;
            disp_char_q <= 8'h00;
        end else begin
            rs_s_q      <= {rs_s_q[0], rs_pin};
            rw_s_q      <= {rw_s_q[0], rw_pin};
            e_s_q       <= {e_s_q[0], e_pin};
            data_s1_q   <= data_pins;
            data_s2_q   <= data_s1_q;
            rs_p_q      <= rs_s_q[1];
            rw_p_q      <= rw_s_q[1];
            e_p_q       <= e_s_q[1];
            data_p_q    <= data_s2_q;
            state_q     <= state_d;
            fill_idx_q  <= fill_idx_d;
            cnt_q       <= cnt_d;
            ac_q        <= ac_d;
            id_q        <= id_d;
            disp_q      <= disp_d;
            curs_q      <= curs_d;
            blink_q     <= blink_d;
            // Read-before-write: a same-cycle write shows up one cycle later.
            disp_char_q <= mem_q[disp_addr];
        end
    end

    // DDRAM contents are initialised by the post-reset clear fill.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    // ------------------------------------------------------------------
    // Dropped-access counter
    // ------------------------------------------------------------------
`ifdef LCD_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
    assign drop_count  = '0;
`endif

    // ------------------------------------------------------------------
    // Bus drive, combinational on the raw pins
    // ------------------------------------------------------------------
    assign rd_val    = rs_pin ? mem_q[ac_idx(ac_q)] : {busy, ac_q};
    assign data_pins = (e_pin && rw_pin) ? rd_val : 8'bz;

    assign disp_char   = disp_char_q;
    assign display_on  = disp_q;
    assign cursor_on   = curs_q;
    assign blink_on    = blink_q;
    assign cursor_addr = ac_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_responder.sv
// ============================================================================
// Module      : tb_lcd_responder
// Description : Directed self-checking bench for lcd_responder. Honours the
//               LCD_DROP_CNT_EN build macro for the drop-counter expectation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_responder;

    logic       clk;
    logic       rst;
    logic       rs_pin, rw_pin, e_pin;
    logic       tb_drv;
    logic [7:0] tb_dat;
    wire  [7:0] bus;
    logic [4:0] disp_addr;
    logic [7:0] disp_char;
    logic       display_on, cursor_on, blink_on;
    logic [6:0] cursor_addr;
    logic [7:0] drop_count;

    int n_vec;
    int n_err;

    assign bus = tb_drv ? tb_dat : 8'bz;

    lcd_responder #(
        .BUSY_CYCLES       (40),
        .CLEAR_BUSY_CYCLES (160),
        .DROP_CNT_W        (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rs_pin      (rs_pin),
        .rw_pin      (rw_pin),
        .e_pin       (e_pin),
        .data_pins   (bus),
        .disp_addr   (disp_addr),
        .disp_char   (disp_char),
        .display_on  (display_on),
        .cursor_on   (cursor_on),
        .blink_on    (blink_on),
        .cursor_addr (cursor_addr),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input logic rs, input logic [7:0] d);
        rs_pin = rs; rw_pin = 1'b0; tb_dat = d; tb_drv = 1'b1;
        tick();
        e_pin = 1'b1;
        repeat (3) tick();
        e_pin = 1'b0;
        repeat (5) tick();
        tb_drv = 1'b0;
    endtask

    task automatic status_rd(output logic [7:0] v);
        tb_drv = 1'b0; rs_pin = 1'b0; rw_pin = 1'b1; e_pin = 1'b1;
        tick();
        v = bus;
        e_pin = 1'b0;
        repeat (2) tick();
    endtask

    task automatic wait_ready(input string tag);
        bit done;
        done = 1'b0;
        tb_drv = 1'b0; rs_pin = 1'b0; rw_pin = 1'b1; e_pin = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            tick();
            if (bus[7] == 1'b0) done = 1'b1;
        end
        if (!done) chk({tag, "_timeout"}, 16'd0, 16'd1);
        e_pin = 1'b0;
        repeat (4) tick();
    endtask

    task automatic side_rd(input logic [4:0] idx, output logic [7:0] v);
        disp_addr = idx;
        tick();
        v = disp_char;
    endtask

    task automatic wr_data(input logic [7:0] d);
        host_wr(1'b1, d);
        wait_ready("wr");
    endtask

    task automatic cmd(input logic [7:0] d);
        host_wr(1'b0, d);
        wait_ready("cmd");
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] exp_drop;
        n_vec = 0; n_err = 0;
        rst = 1'b1; rs_pin = 1'b0; rw_pin = 1'b0; e_pin = 1'b0;
        tb_drv = 1'b0; tb_dat = 8'h00; disp_addr = 5'd0;
`ifdef LCD_DROP_CNT_EN
        exp_drop = 8'd7;
`else
        exp_drop = 8'd0;
`endif

        // Reset state
        repeat (3) tick();
        chk("rst_ac", 16'(cursor_addr), 16'h00);
        chk("rst_disp", 16'(display_on), 16'h0);
        chk("rst_char", 16'(disp_char), 16'h00);
        chk("rst_drop", 16'(drop_count), 16'h00);
        rst = 1'b0;

        // Power-on clear: busy then idle, whole screen blank
        status_rd(v);
        chk("por_busy", 16'(v), 16'h80);
        repeat (200) tick();
        status_rd(v);
        chk("por_idle", 16'(v), 16'h00);
        for (int i = 0; i < 32; i++) begin
            side_rd(5'(i), v);
            chk($sformatf("por_blank%0d", i), 16'(v), 16'h20);
        end

        // Display control and set-address
        cmd(8'h0E);
        cmd(8'hC5);
        chk("flag_d", 16'(display_on), 16'h1);
        chk("flag_c", 16'(cursor_on), 16'h1);
        chk("flag_b", 16'(blink_on), 16'h0);
        status_rd(v);
        chk("stat_45", 16'(v), 16'h45);

        // 17 increments wrap line 0 into line 1
        cmd(8'h80);
        for (int i = 0; i < 17; i++) wr_data(8'h41);
        side_rd(5'd0, v);  chk("inc_idx0", 16'(v), 16'h41);
        side_rd(5'd15, v); chk("inc_idx15", 16'(v), 16'h41);
        side_rd(5'd16, v); chk("inc_idx16", 16'(v), 16'h41);
        side_rd(5'd17, v); chk("inc_idx17", 16'(v), 16'h20);
        chk("inc_ac", 16'(cursor_addr), 16'h41);

        // Decrement wrap 0x00 -> 0x4F, then data read steps AC without busy
        cmd(8'h04);
        cmd(8'h80);
        wr_data(8'h31);
        side_rd(5'd0, v); chk("dec_idx0", 16'(v), 16'h31);
        chk("dec_ac", 16'(cursor_addr), 16'h4F);
        rs_pin = 1'b1; rw_pin = 1'b1; e_pin = 1'b1;
        tick();
        chk("rd_val", 16'(bus), 16'h20);
        e_pin = 1'b0;
        repeat (5) tick();
        chk("rd_ac", 16'(cursor_addr), 16'h4E);
        status_rd(v);
        chk("rd_nobusy", 16'(v), 16'h4E);

        // Writes every 10 clocks: accepted at 0 and 50, seven dropped
        cmd(8'h06);
        cmd(8'h80);
        rs_pin = 1'b1; rw_pin = 1'b0; tb_dat = 8'h42; tb_drv = 1'b1;
        for (int i = 0; i < 9; i++) begin
            e_pin = 1'b1;
            repeat (2) tick();
            e_pin = 1'b0;
            repeat (8) tick();
        end
        tb_drv = 1'b0;
        wait_ready("burst");
        side_rd(5'd0, v); chk("burst_idx0", 16'(v), 16'h42);
        side_rd(5'd1, v); chk("burst_idx1", 16'(v), 16'h42);
        side_rd(5'd2, v); chk("burst_idx2", 16'(v), 16'h41);
        chk("burst_ac", 16'(cursor_addr), 16'h02);
        chk("burst_drop", 16'(drop_count), 16'(exp_drop));

        // Reset during clear fill: asynchronous effect, fill restarts
        host_wr(1'b0, 8'h01);
        repeat (6) tick();
        rst = 1'b1;
        #1;
        chk("midclr_disp", 16'(display_on), 16'h0);
        chk("midclr_curs", 16'(cursor_on), 16'h0);
        chk("midclr_char", 16'(disp_char), 16'h00);
        repeat (3) tick();
        rst = 1'b0;
        status_rd(v);
        chk("midclr_busy", 16'(v), 16'h80);
        wait_ready("midclr");
        side_rd(5'd16, v); chk("midclr_idx16", 16'(v), 16'h20);
        side_rd(5'd31, v); chk("midclr_idx31", 16'(v), 16'h20);

        // Reset in the middle of a write access
        cmd(8'h80);
        for (int i = 0; i < 3; i++) wr_data(8'h55);
        side_rd(5'd2, v); chk("pre_idx2", 16'(v), 16'h55);
        rs_pin = 1'b1; rw_pin = 1'b0; tb_dat = 8'h66; tb_drv = 1'b1;
        e_pin = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        chk("midacc_ac", 16'(cursor_addr), 16'h00);
        chk("midacc_drop", 16'(drop_count), 16'h00);
        e_pin = 1'b0; tb_drv = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        wait_ready("midacc");
        for (int i = 0; i < 4; i++) begin
            side_rd(5'(i), v);
            chk($sformatf("midacc_idx%0d", i), 16'(v), 16'h20);
        end
        chk("midacc_ac2", 16'(cursor_addr), 16'h00);
        chk("midacc_drop2", 16'(drop_count), 16'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lcd_responder.md
Name: lcd_responder

Overview:
- HD44780-compatible bus responder: the device end of the 8-bit LCD parallel bus (rs/rw/e/data).
- Decodes a host's status reads, command writes and data writes.
- Holds a 2x16 character DDRAM and display-control flags.
- A registered side port lets a text renderer (e.g. VGA overlay) or a bench scoreboard read screen contents.

Parameters:
BUSY_CYCLES, 40, clk cycles busy flag stays set after a non-clear command or a data write
CLEAR_BUSY_CYCLES, 160, busy cycles after clear/return-home; must be >= 32 (clear fill length)
DROP_CNT_W, 8, width of dropped-access counter (feature only)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
rs_pin  input  1  register select: 0 = instruction/status, 1 = data
rw_pin  input  1  1 = host read, 0 = host write
e_pin  input  1  enable strobe; access latched on its falling edge
data_pins  inout  8  bidirectional bus; driven only during host reads
disp_addr  input  5  side-port index {line, column[3:0]}
disp_char  output  8  DDRAM[disp_addr], 1-cycle registered latency
display_on  output  1  D flag
cursor_on  output  1  C flag
blink_on  output  1  B flag
cursor_addr  output  7  current address counter (AC)
drop_count  output  DROP_CNT_W  accesses ignored while busy (0 without feature)

Behaviour:
- Single clock domain. Decided: one clock; reset is asynchronous and active-high (clk, rst).
- Input sync: rs/rw/e/data pass through 2-stage synchronisers. Falling edge = synced e 1 then 0. The access uses the synced rs/rw/data from the last cycle e was high.
- Bus drive (combinational on raw pins, no contention): data_pins = (e_pin && rw_pin) ? rd_val : 'z.
  - rd_val = rs_pin ? DDRAM[idx(AC)] : {busy, AC}.
- Address map: valid AC is 0x00-0x0F (line 0) and 0x40-0x4F (line 1). idx(AC) = {AC[6], AC[3:0]}. Set-address masks bits 5:4 to 0.
- AC step: I/D=1 increments 0x0F->0x40, 0x4F->0x00. I/D=0 decrements 0x00->0x4F, 0x40->0x0F.
- Decode on falling edge, when busy=0:
  - rs=0,rw=0 (command), highest set bit wins:
    - 0x80|a: AC = {a[6],00,a[3:0]}
    - 0x20-0x7F (function set, CGRAM addr): no effect beyond busy
    - 0x10-0x1F: no effect beyond busy (shift unsupported)
    - 0x08-0x0F: D/C/B = bits 2/1/0
    - 0x04-0x07: I/D = bit1 (S ignored)
    - 0x02/0x03: AC = 0, busy CLEAR_BUSY_CYCLES
    - 0x01: clear (below)
    - 0x00: ignored, no busy
  - rs=1,rw=0 (data write): DDRAM[idx(AC)] = data; AC steps.
  - rs=1,rw=1 (data read): AC steps after the read; no busy.
  - rs=0,rw=1 (status read): no state change.
- Busy: on the cycle after an accepted write/command, busy=1 and the counter loads BUSY_CYCLES (or CLEAR_BUSY_CYCLES). Counter decrements each clk; busy=0 when it reaches 0.
- Busy drops: write/command/data-read edges seen while busy=1 are ignored (no state change). Status reads are always serviced.
- Clear state machine:
  - States: IDLE -> CLEAR_FILL (32 cycles, one entry per cycle = 0x20, index 0..31) -> IDLE.
  - On entering CLEAR_FILL: AC=0, I/D=1.
  - Busy stays 1 for the full CLEAR_BUSY_CYCLES.
- Reset (any time, incl. mid-clear or mid-access):
  - AC=0, I/D=1, display_on=cursor_on=blink_on=0, drop_count=0, disp_char=0, synchronisers=0.
  - Then an internal clear starts: CLEAR_FILL from index 0, busy=1, counter=CLEAR_BUSY_CYCLES.
- Side port: disp_char updates every clk from disp_addr, independent of bus traffic. A same-cycle write becomes visible one cycle later (read-before-write).

Optional Feature:
- Macro: LCD_DROP_CNT_EN.
- Defined: drop_count increments (saturating at all-ones) per write/command/data-read falling edge ignored due to busy. Cleared only by rst.
- Undefined: no counter logic; drop_count tied to 0.

Test Plan:
- Release rst, poll status (rs=0,rw=1,e=1) -> bus 0x80 until ~160 clk, then 0x00; every side-port index reads 0x20.
- Cmd 0x0E, then 0xC5 -> display_on=1, cursor_on=1, blink_on=0; after busy clears, status = 0x45.
- After 0x80, write 'A'(0x41) x17 -> DDRAM 0..15 = 0x41, index 16 (0x40) = 0x41, AC=0x41.
- Cmd 0x04, 0x80, write 0x31 -> DDRAM[0]=0x31, AC=0x4F; data read returns DDRAM[31], AC=0x4E.
- Write 0x42 every 10 clk (BUSY_CYCLES=40) -> intermediate writes dropped; with LCD_DROP_CNT_EN, drop_count equals the dropped count.
- Assert rst during CLEAR_FILL and mid-burst -> outputs reach reset values immediately; full fill restarts from index 0.
